// File: rtl/dcache_write_buffer.sv
// -----------------------------------------------------------------------------
// dcache_write_buffer
//
// Write-back buffer between the dcache controller and Data_Memory on the
// 256-bit line bus. Dirty-line evictions are acknowledged as soon as they are
// queued, so the cache never waits on memory. Queued lines drain to memory in
// the background. A read to a line still held in the buffer is answered from
// the buffer. A read miss goes to memory ahead of any queued drains.
//
// Handshakes:
//   cache side : the cache raises cache_enable_i and holds the request stable
//                until cache_ack_o pulses for one cycle. A request is taken
//                on an edge with cache_enable_i=1 and cache_ack_o=0, and only
//                while no read miss is outstanding. A write that finds the
//                FIFO full is not taken; it waits for a drain to complete.
//   memory side: mem_enable_o is held, with addr/data/write stable, until
//                mem_ack_i pulses. mem_ack_i is ignored while mem_enable_o=0.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cache_addr_i/data_i          request byte address (line aligned) / write data
//   cache_enable_i/write_i       request valid / 1=write-back, 0=line read
//   cache_ack_o/data_o           completion pulse / read data (valid with ack)
//   mem_addr_o/data_o            memory request address / write data
//   mem_enable_o/write_o         memory request valid / type
//   mem_ack_i/data_i             memory completion pulse / read data
//   empty_o                      no line queued, memory idle, no read pending
//   dbg_state_o                  current FSM state (IDLE=0 DRAIN=1 READ=2 GAP=3)
// -----------------------------------------------------------------------------
module dcache_write_buffer #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cache_addr_i,
  input  logic [LINE_W-1:0] cache_data_i,
  input  logic              cache_enable_i,
  input  logic              cache_write_i,
  output logic              cache_ack_o,
  output logic [LINE_W-1:0] cache_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              empty_o,
  output logic [1:0]        dbg_state_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LA_W  = ADDR_W - 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_READ  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t state;

  // FIFO storage: line address and data per entry
  logic [LA_W-1:0]   la_q   [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  // Outstanding read miss
  logic              rd_pending;
  logic [LA_W-1:0]   rd_la;

  logic [LA_W-1:0]   req_la;
  logic              accept;
  logic              start_drain;
  logic              head_busy;
  logic              pop;
  logic              hit;
  logic [PTR_W-1:0]  hit_idx;
  logic              wr_hit;
  logic              wr_push;
  logic              rd_hit;
  logic              rd_miss;
  logic              unused_addr_lsb;

  assign req_la          = cache_addr_i[ADDR_W-1:5];
  assign unused_addr_lsb = ^cache_addr_i[4:0];

  assign accept      = cache_enable_i && !cache_ack_o && !rd_pending;
  assign start_drain = (state == S_IDLE) && !rd_pending && (count != '0);
  // The head is owned by memory once a drain is launched (including the
  // launching edge itself, where its data is copied into mem_data_o), so it
  // must not be overwritten or used as a read source from then on.
  assign head_busy   = (state == S_DRAIN) || start_drain;
  assign pop         = (state == S_DRAIN) && mem_ack_i;

  // Address match over the valid entries, oldest to youngest; the last match
  // wins so a read sees the youngest copy of a line.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && !(i == 0 && head_busy) &&
          (la_q[head + PTR_W'(i)] == req_la)) begin
        hit     = 1'b1;
        hit_idx = head + PTR_W'(i);
      end
    end
  end

  assign wr_hit  = accept && cache_write_i && hit;
  // A full FIFO may still take a push on the edge that pops the head.
  assign wr_push = accept && cache_write_i && !hit &&
                   ((count < CNT_W'(DEPTH)) || pop);
  assign rd_hit  = accept && !cache_write_i && hit;
  assign rd_miss = accept && !cache_write_i && !hit;

  assign empty_o     = (count == '0) && (state == S_IDLE) && !rd_pending;
  assign dbg_state_o = state;

  // Entry storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk_i) begin
    if (wr_push) begin
      la_q[tail]   <= req_la;
      data_q[tail] <= cache_data_i;
    end else if (wr_hit) begin
      data_q[hit_idx] <= cache_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      rd_pending   <= 1'b0;
      rd_la        <= '0;
      cache_ack_o  <= 1'b0;
      cache_data_o <= '0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
    end else begin
      cache_ack_o <= 1'b0;

      if (wr_hit || wr_push || rd_hit) begin
        cache_ack_o <= 1'b1;
      end
      if (rd_hit) begin
        cache_data_o <= data_q[hit_idx];
      end
      if (rd_miss) begin
        rd_pending <= 1'b1;
        rd_la      <= req_la;
      end

      if (wr_push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({wr_push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      case (state)
        S_IDLE: begin
          // A pending read miss bypasses queued drains.
          if (rd_pending) begin
            state        <= S_READ;
            mem_enable_o <= 1'b1;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= {rd_la, 5'b0};
          end else if (count != '0) begin
            state        <= S_DRAIN;
            mem_enable_o <= 1'b1;
            mem_write_o  <= 1'b1;
            mem_addr_o   <= {la_q[head], 5'b0};
            mem_data_o   <= data_q[head];
          end
        end
        S_DRAIN: begin
          if (mem_ack_i) begin
            state        <= S_GAP;
            mem_enable_o <= 1'b0;
          end
        end
        S_READ: begin
          if (mem_ack_i) begin
            state        <= S_GAP;
            mem_enable_o <= 1'b0;
            cache_data_o <= mem_data_i;
            cache_ack_o  <= 1'b1;
            rd_pending   <= 1'b0;
          end
        end
        S_GAP: begin
          // One idle cycle on the memory port between requests.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// -----------------------------------------------------------------------------
// Directed bench for dcache_write_buffer. A behavioural memory answers on the
// negative edge with a programmable delay; every memory operation it sees is
// checked against exp_q ({write, addr}) in order.
// -----------------------------------------------------------------------------
module tb_dcache_write_buffer;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int CW     = LINE_W + 1;
  localparam int OPW    = ADDR_W + 1;

  localparam logic [LINE_W-1:0] D1  = {8{32'hD1D1_0001}};
  localparam logic [LINE_W-1:0] E0  = {8{32'hE0E0_0000}};
  localparam logic [LINE_W-1:0] E1  = {8{32'hE1E1_0001}};
  localparam logic [LINE_W-1:0] E2  = {8{32'hE2E2_0002}};
  localparam logic [LINE_W-1:0] P3  = {8{32'hA3A3_0100}};
  localparam logic [LINE_W-1:0] D2  = {8{32'hD2D2_0200}};
  localparam logic [LINE_W-1:0] Q4  = {8{32'hA4A4_0100}};
  localparam logic [LINE_W-1:0] X4  = {8{32'hBAD0_0000}};
  localparam logic [LINE_W-1:0] Y4  = {8{32'h600D_0000}};
  localparam logic [LINE_W-1:0] R5  = {8{32'hA5A5_0100}};
  localparam logic [LINE_W-1:0] S5  = {8{32'h5555_0300}};
  localparam logic [LINE_W-1:0] M17 = {8{32'h1717_0220}};
  localparam logic [LINE_W-1:0] D3  = {8{32'hD3D3_0400}};
  localparam logic [LINE_W-1:0] D4  = {8{32'hD4D4_0440}};
  localparam logic [LINE_W-1:0] Z7  = {8{32'h7777_0060}};

  // ---------------- clock / reset ----------------
  logic              clk_i = 1'b0;
  logic              rst_i;
  always #5 clk_i = ~clk_i;

  logic [ADDR_W-1:0] cache_addr_i;
  logic [LINE_W-1:0] cache_data_i;
  logic              cache_enable_i;
  logic              cache_write_i;
  logic              cache_ack_o;
  logic [LINE_W-1:0] cache_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_i;
  logic              empty_o;
  logic [1:0]        dbg_state_o;

  dcache_write_buffer #(.DEPTH(2), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cache_addr_i   (cache_addr_i),
    .cache_data_i   (cache_data_i),
    .cache_enable_i (cache_enable_i),
    .cache_write_i  (cache_write_i),
    .cache_ack_o    (cache_ack_o),
    .cache_data_o   (cache_data_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_ack_i      (mem_ack_i),
    .mem_data_i     (mem_data_i),
    .empty_o        (empty_o),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [OPW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [LINE_W-1:0] mem [0:63];
  int                mem_delay = 0;
  int                age       = 0;
  bit                started   = 0;
  int                wr_cnt    = 0;
  int                rd_cnt    = 0;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_data;
  logic              lat_wr;
  logic [OPW-1:0]    op;
  logic [OPW-1:0]    exp_op;

  always @(negedge clk_i) begin
    if (rst_i) begin
      mem_ack_i = 1'b0;
      started   = 0;
      age       = 0;
    end else if (mem_ack_i) begin
      mem_ack_i = 1'b0;
    end else if (mem_enable_o) begin
      if (!started) begin
        lat_addr = mem_addr_o;
        lat_data = mem_data_o;
        lat_wr   = mem_write_o;
        started  = 1;
        age      = 0;
      end else begin
        age++;
      end
      if (age >= mem_delay) begin
        if (age > 0) begin
          check("mem_req_stable", CW'({lat_wr, lat_addr, lat_data}),
                CW'({mem_write_o, mem_addr_o, mem_data_o}));
        end
        op = {mem_write_o, mem_addr_o};
        check("mem_op_expected", CW'(exp_q.size() > 0), CW'(1));
        if (exp_q.size() > 0) begin
          exp_op = exp_q.pop_front();
          check("mem_op_order", CW'(op), CW'(exp_op));
        end
        if (mem_write_o) begin
          mem[mem_addr_o[10:5]] = mem_data_o;
          wr_cnt++;
        end else begin
          mem_data_i = mem[mem_addr_o[10:5]];
          rd_cnt++;
        end
        mem_ack_i = 1'b1;
        started   = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns one cycle after the ack.
  task automatic cache_req(input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] data,
                           output int cycles, output logic [LINE_W-1:0] rdata);
    bit done;
    cache_enable_i = 1'b1;
    cache_write_i  = wr;
    cache_addr_i   = addr;
    cache_data_i   = data;
    cycles = 0;
    rdata  = '0;
    done   = 0;
    while (!done) begin
      @(posedge clk_i); #1;
      cycles++;
      if (cache_ack_o) begin
        rdata = cache_data_o;
        done  = 1;
      end else if (cycles >= 300) begin
        check("cache_ack_timeout", CW'(cache_ack_o), CW'(1));
        done = 1;
      end
    end
    cache_enable_i = 1'b0;
    cache_write_i  = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!empty_o && n < 300) begin
      @(posedge clk_i); #1;
      n++;
    end
    check(tag, CW'(empty_o), CW'(1));
  endtask

  // ---------------- directed sequence ----------------
  int                cyc;
  logic [LINE_W-1:0] rd;
  int                base_wr;
  int                base_rd;

  initial begin
    rst_i          = 1'b1;
    cache_addr_i   = '0;
    cache_data_i   = '0;
    cache_enable_i = 1'b0;
    cache_write_i  = 1'b0;
    mem_ack_i      = 1'b0;
    mem_data_i     = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[17] = M17;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_cache_ack",  CW'(cache_ack_o),  CW'(0));
    check("rst_cache_data", CW'(cache_data_o), CW'(0));
    check("rst_mem_enable", CW'(mem_enable_o), CW'(0));
    check("rst_mem_write",  CW'(mem_write_o),  CW'(0));
    check("rst_mem_addr",   CW'(mem_addr_o),   CW'(0));
    check("rst_mem_data",   CW'(mem_data_o),   CW'(0));
    check("rst_empty",      CW'(empty_o),      CW'(1));
    check("rst_state",      CW'(dbg_state_o),  CW'(0));
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // 1: single write to an empty buffer, drain starts right away
    mem_delay = 0;
    exp_q.push_back({1'b1, 32'h0000_0400});
    cache_req(1'b1, 32'h0400, D1, cyc, rd);
    check("t1_ack_latency", CW'(cyc),          CW'(1));
    check("t1_drain_en",    CW'(mem_enable_o), CW'(1));
    check("t1_drain_wr",    CW'(mem_write_o),  CW'(1));
    check("t1_drain_addr",  CW'(mem_addr_o),   CW'(32'h0400));
    check("t1_drain_data",  CW'(mem_data_o),   CW'(D1));
    check("t1_state_drain", CW'(dbg_state_o),  CW'(1));
    check("t1_not_empty",   CW'(empty_o),      CW'(0));
    @(posedge clk_i); #1;
    check("t1_gap_en",      CW'(mem_enable_o), CW'(0));
    check("t1_state_gap",   CW'(dbg_state_o),  CW'(3));
    @(posedge clk_i); #1;
    check("t1_state_idle",  CW'(dbg_state_o),  CW'(0));
    check("t1_empty",       CW'(empty_o),      CW'(1));
    check("t1_mem32",       CW'(mem[32]),      CW'(D1));

    // 2: third write withheld while full, released by the first pop
    mem_delay = 10;
    exp_q.push_back({1'b1, 32'h0000_0000});
    exp_q.push_back({1'b1, 32'h0000_0020});
    exp_q.push_back({1'b1, 32'h0000_0040});
    base_wr = wr_cnt;
    cache_req(1'b1, 32'h0000, E0, cyc, rd);
    check("t2_w0_latency", CW'(cyc), CW'(1));
    cache_req(1'b1, 32'h0020, E1, cyc, rd);
    check("t2_w1_latency", CW'(cyc), CW'(1));
    cache_req(1'b1, 32'h0040, E2, cyc, rd);
    check("t2_w2_withheld", CW'(cyc), CW'(9));
    check("t2_pops_at_ack", CW'(wr_cnt - base_wr), CW'(1));
    wait_idle("t2_idle");
    check("t2_mem0", CW'(mem[0]), CW'(E0));
    check("t2_mem1", CW'(mem[1]), CW'(E1));
    check("t2_mem2", CW'(mem[2]), CW'(E2));
    check("t2_ops_done", CW'(exp_q.size()), CW'(0));

    // 3: read hit on a queued line, no memory read
    mem_delay = 10;
    exp_q.push_back({1'b1, 32'h0000_0100});
    exp_q.push_back({1'b1, 32'h0000_0200});
    base_rd = rd_cnt;
    cache_req(1'b1, 32'h0100, P3, cyc, rd);
    cache_req(1'b1, 32'h0200, D2, cyc, rd);
    check("t3_w_latency", CW'(cyc), CW'(1));
    cache_req(1'b0, 32'h0200, '0, cyc, rd);
    check("t3_rd_latency", CW'(cyc), CW'(1));
    check("t3_rd_data",    CW'(rd),  CW'(D2));
    wait_idle("t3_idle");
    check("t3_no_mem_read", CW'(rd_cnt - base_rd), CW'(0));
    check("t3_mem16",       CW'(mem[16]), CW'(D2));
    check("t3_ops_done",    CW'(exp_q.size()), CW'(0));

    // 4: overwrite of a queued (not draining) line while the FIFO is full
    mem_delay = 10;
    exp_q.push_back({1'b1, 32'h0000_0100});
    exp_q.push_back({1'b1, 32'h0000_0000});
    cache_req(1'b1, 32'h0100, Q4, cyc, rd);
    cache_req(1'b1, 32'h0000, X4, cyc, rd);
    check("t4_x_latency", CW'(cyc), CW'(1));
    cache_req(1'b1, 32'h0000, Y4, cyc, rd);
    check("t4_y_latency", CW'(cyc), CW'(1));
    wait_idle("t4_idle");
    check("t4_mem0",     CW'(mem[0]), CW'(Y4));
    check("t4_ops_done", CW'(exp_q.size()), CW'(0));

    // 5: read miss bypasses the queued drain
    mem_delay = 10;
    exp_q.push_back({1'b1, 32'h0000_0100});
    exp_q.push_back({1'b0, 32'h0000_0220});
    exp_q.push_back({1'b1, 32'h0000_0300});
    base_rd = rd_cnt;
    cache_req(1'b1, 32'h0100, R5, cyc, rd);
    cache_req(1'b1, 32'h0300, S5, cyc, rd);
    cache_req(1'b0, 32'h0220, '0, cyc, rd);
    check("t5_rd_data",  CW'(rd), CW'(M17));
    check("t5_mem_read", CW'(rd_cnt - base_rd), CW'(1));
    wait_idle("t5_idle");
    check("t5_mem24",     CW'(mem[24]), CW'(S5));
    check("t5_ops_done",  CW'(exp_q.size()), CW'(0));

    // 6: reset during DRAIN discards the in-flight drain and the queue
    mem_delay = 20;
    base_wr = wr_cnt;
    cache_req(1'b1, 32'h0400, D3, cyc, rd);
    cache_req(1'b1, 32'h0440, D4, cyc, rd);
    check("t6_drain_en", CW'(mem_enable_o), CW'(1));
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("t6_rst_mem_en",  CW'(mem_enable_o), CW'(0));
    check("t6_rst_empty",   CW'(empty_o),      CW'(1));
    check("t6_rst_ack",     CW'(cache_ack_o),  CW'(0));
    check("t6_rst_state",   CW'(dbg_state_o),  CW'(0));
    rst_i = 1'b0;
    repeat (40) @(posedge clk_i);
    #1;
    check("t6_no_writes",   CW'(wr_cnt - base_wr), CW'(0));
    check("t6_still_empty", CW'(empty_o), CW'(1));
    check("t6_mem32_kept",  CW'(mem[32]), CW'(D1));

    // 7: normal operation after the reset
    mem_delay = 0;
    exp_q.push_back({1'b1, 32'h0000_0060});
    cache_req(1'b1, 32'h0060, Z7, cyc, rd);
    check("t7_latency", CW'(cyc), CW'(1));
    wait_idle("t7_idle");
    check("t7_mem3",     CW'(mem[3]), CW'(Z7));
    check("t7_ops_done", CW'(exp_q.size()), CW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
